// File: rtl/tile_result_accumulator.sv
// Tile result accumulator.
// Sums the num_row x num_col partial-product matrices of num_tiles consecutive
// K-dimension tiles element-wise, then streams the final matrix out one element
// per valid/ready handshake. Tiles are accepted one per cycle while
// accumulating; tile input is stalled (tile_ready=0) while draining.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   tile_valid/ready  tile handshake; pe_register_vals carries the packed tile
//                     (element 0 in the most significant word)
//   tile_count        tiles summed into the current matrix
//   result_valid/ready, result_data, result_index, result_last
//                     output element stream, index 0..N-1, last on N-1
module tile_result_accumulator #(
  parameter int unsigned out_word_size = 24,
  parameter int unsigned acc_word_size = 32,
  parameter int unsigned num_row       = 3,
  parameter int unsigned num_col       = 3,
  parameter int unsigned num_tiles     = 9
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              tile_valid,
  output logic                                              tile_ready,
  input  logic [out_word_size*num_row*num_col-1:0]          pe_register_vals,
  output logic [$clog2(num_tiles+1)-1:0]                    tile_count,
  output logic                                              result_valid,
  input  logic                                              result_ready,
  output logic [acc_word_size-1:0]                          result_data,
  output logic [((num_row*num_col) > 1 ? $clog2(num_row*num_col) : 1)-1:0] result_index,
  output logic                                              result_last
);

  localparam int unsigned num_elem = num_row * num_col;
  localparam int unsigned in_w     = out_word_size * num_elem;
  localparam int unsigned cnt_w    = $clog2(num_tiles + 1);
  localparam int unsigned idx_w    = (num_elem > 1) ? $clog2(num_elem) : 1;

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     tile_accept;
  logic                     elem_accept;
  logic                     last_tile;
  logic                     last_elem;
  logic [idx_w-1:0]         idx_inc;
  logic [acc_word_size-1:0] acc     [num_elem];
  logic [acc_word_size-1:0] acc_sum [num_elem];

  // Next accumulator value per element; the first tile of a matrix overwrites.
  for (genvar e = 0; e < num_elem; e++) begin : g_sum
    logic [out_word_size-1:0] elem;
    logic [acc_word_size-1:0] elem_ext;
    assign elem     = pe_register_vals[in_w-1-e*out_word_size -: out_word_size];
    assign elem_ext = acc_word_size'(elem);
    assign acc_sum[e] = (tile_count == '0) ? elem_ext : acc[e] + elem_ext;
  end

  assign idx_inc = result_index + idx_w'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next  = state;
    tile_accept = 1'b0;
    elem_accept = 1'b0;
    last_tile   = 1'b0;
    last_elem   = 1'b0;
    case (state)
      ACCUM: begin
        tile_accept = tile_valid && tile_ready;
        last_tile   = (tile_count == cnt_w'(num_tiles - 1));
        if (tile_accept && last_tile) state_next = DRAIN;
      end
      DRAIN: begin
        elem_accept = result_valid && result_ready;
        last_elem   = (result_index == idx_w'(num_elem - 1));
        if (elem_accept && last_elem) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Accumulators, tile counter and registered output stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '{default: '0};
      tile_count   <= '0;
      tile_ready   <= 1'b1;
      result_valid <= 1'b0;
      result_last  <= 1'b0;
      result_index <= '0;
      result_data  <= '0;
    end else begin
      if (tile_accept) begin
        acc        <= acc_sum;
        tile_count <= tile_count + cnt_w'(1);
        if (last_tile) begin
          tile_ready   <= 1'b0;
          result_valid <= 1'b1;
          result_index <= '0;
          result_data  <= acc_sum[0];
          result_last  <= (num_elem == 1);
        end
      end
      if (elem_accept) begin
        if (last_elem) begin
          tile_count   <= '0;
          tile_ready   <= 1'b1;
          result_valid <= 1'b0;
          result_last  <= 1'b0;
          result_index <= '0;
        end else begin
          result_index <= idx_inc;
          result_data  <= acc[idx_inc];
          result_last  <= (idx_inc == idx_w'(num_elem - 1));
        end
      end
    end
  end

endmodule

// File: doc/tile_result_accumulator.md
Name: tile_result_accumulator

Overview:
- Downstream of the systolic_array tile engine. Collects the num_row x num_col partial-product matrix each tile produces and sums it element-wise over num_tiles K-dimension tiles.
- Once the last tile is summed, streams the final matrix out one element per handshake.
- Replaces the bench-level accumulator bank and tile_element counter with a self-contained, back-pressurable stage.

Parameters:
- out_word_size, 24, width of each PE result element in the input bus
- acc_word_size, 32, width of each accumulator and of result_data (must be >= out_word_size)
- num_row, 3, rows of the tile result matrix
- num_col, 3, columns of the tile result matrix
- num_tiles, 9, tiles summed per output matrix (>= 1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- tile_valid  in  1  pe_register_vals holds a finished tile; driven from systolic_array compute_done
- tile_ready  out  1  block can accept a tile this cycle
- pe_register_vals  in  out_word_size*num_row*num_col  packed tile results; element e = r*num_col+c occupies bits counted from MSB: [e*out_word_size : (e+1)*out_word_size-1] in big-endian [0:N-1] numbering
- tile_count  out  clog2(num_tiles+1)  tiles accumulated into current matrix
- result_valid  out  1  result_data/result_index valid
- result_ready  in  1  consumer accepts current element
- result_data  out  acc_word_size  final sum for element result_index
- result_index  out  clog2(num_row*num_col)  element index e of result_data
- result_last  out  1  high with result_valid on element N-1 (N = num_row*num_col)

Behaviour:
- Reset (sync, high):
  - state=ACCUM; all accumulators=0; tile_count=0; drain index=0.
  - result_valid=0; result_last=0; result_index=0.
  - tile_ready=1 from the first cycle after reset deasserts.
- Tile accept: tile_valid & tile_ready at a rising edge.
- ACCUM state:
  - tile_ready=1; result_valid=0.
  - On tile accept with tile_count==0: acc[e] <= zero-extended element e, overwriting the previous matrix (no clear cycle needed).
  - On tile accept with tile_count>0: acc[e] <= acc[e] + zero-extended element e, modulo 2^acc_word_size (unsigned, wraps, no saturation).
  - Each accept increments tile_count.
  - If the accepted tile is tile number num_tiles: next state=DRAIN, tile_count holds num_tiles, drain index=0.
- DRAIN state:
  - tile_ready=0; tile_valid is ignored and upstream must hold it.
  - result_valid=1 from the first cycle after the final tile accept (latency 1 cycle from final accept to first element).
  - result_data = acc[drain index]; result_index = drain index; result_last = (drain index==N-1).
  - Outputs stay stable while result_ready=0.
  - On result_valid & result_ready: drain index increments.
  - On acceptance of element N-1: next state=ACCUM, tile_count=0, result_valid=0 the following cycle, tile_ready=1 the same following cycle.
  - Accumulator contents persist until the next first-tile overwrite.
- Throughput:
  - One tile per cycle in ACCUM (back-to-back tile_valid allowed).
  - One element per cycle in DRAIN with result_ready held high.
  - Full cycle = num_tiles + N cycles minimum.
- num_tiles==1: each accepted tile goes straight to DRAIN with acc = the tile.
- result_ready high outside DRAIN: no effect.
- Reset during ACCUM or DRAIN: partial sums discarded, returns to the reset state next cycle; no result emitted.
- tile_valid asserted on the same edge DRAIN ends: not accepted (tile_ready=0 that cycle); it is accepted on the next edge.

Test Plan:
- Defaults (3x3, num_tiles=9), all elements=1 on every tile for 9 consecutive cycles -> tile_ready low after the 9th accept; 9 results all =9, indices 0..8, result_last only on index 8.
- num_tiles=3, tile k (k=1..3) element e = 10*k+e -> result e = 60+3e (index 0 → 60, index 8 → 84).
- Backpressure: result_ready toggles 1,0,0,1,... during DRAIN -> each element is held stable while ready is low; no element skipped or duplicated; exactly 9 handshakes.
- Wrap: acc_word_size=24, num_tiles=2, element 0 = 24'hFFFFFF in both tiles -> result 0 = 24'hFFFFFE.
- tile_valid held high through DRAIN -> no tile accepted until DRAIN ends; the next matrix's first tile overwrites (e.g. all 5, num_tiles=1 → all results 5, not 5 + old sums).
- Reset asserted after 4 of 9 tiles, then 9 tiles of value 2 -> all results 18; result_valid never rises before the new 9th accept.
